// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: FSM encoding, trigger-mode
// constants and the width of the source index.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic MODE_EDGE  = 1'b1;
    localparam logic MODE_LEVEL = 1'b0;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-source synchronizer: SYNC_STAGES flops into the clk domain, then a delay
// flop that yields a registered level and a registered rising-edge pulse.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level_s,
    output logic rise_s
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   rise_q;

    // Edge pulse is registered so level and edge sources see identical latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            dly_q  <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
        end
    end

    assign level_s = dly_q;
    assign rise_s  = rise_q;

endmodule

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: per-source edge/level pending bits, a
// lowest-index-wins request FSM with ack/done handshake and an ack counter.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter  int N_SRC       = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = id_width(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_irq,
    input  logic [N_SRC-1:0] src_edge,
    input  logic [N_SRC-1:0] src_en,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    input  logic             irq_done,
    output logic             busy,
    output logic [N_SRC-1:0] pending,
    output logic [15:0]      ack_count
);

    logic [N_SRC-1:0] level_s, rise_s;
    logic [N_SRC-1:0] pend_q, pend_nxt, ack_clr;
    logic [ID_W-1:0]  low_idx, id_nxt;
    logic             any_hit, cnt_inc;
    state_t           state, state_nxt;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .rst     (rst),
            .raw     (src_irq[g]),
            .level_s (level_s[g]),
            .rise_s  (rise_s[g])
        );
    end

    // A fresh edge in the ack cycle wins over the clear.
    always_comb begin
        ack_clr  = '0;
        pend_nxt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr[i] = (state == ST_REQ) && irq_ack && (irq_id == ID_W'(i));
            if (src_edge[i] == MODE_EDGE)
                pend_nxt[i] = (pend_q[i] & ~ack_clr[i]) | rise_s[i];
            else
                pend_nxt[i] = level_s[i];
        end
    end

    always_comb begin
        any_hit = |(pend_q & src_en);
        low_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (pend_q[i] && src_en[i]) low_idx = ID_W'(i);
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = irq_id;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_hit) begin
                    state_nxt = ST_REQ;
                    id_nxt    = low_idx;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_nxt = ST_SERVICE;
                    cnt_inc   = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (irq_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            irq_id    <= '0;
            pend_q    <= '0;
            ack_count <= '0;
        end else begin
            state  <= state_nxt;
            irq_id <= id_nxt;
            pend_q <= pend_nxt;
            if (cnt_inc) ack_count <= ack_count + 16'd1;
        end
    end

    assign irq_req = (state == ST_REQ);
    assign busy    = (state == ST_SERVICE);
    assign pending = pend_q;

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter N_SRC, default 4: number of interrupt sources, 2..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per source, 2..3.
REQ-003 clk  input  1  single clock, CPU clock domain; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 src_irq  input  N_SRC  raw interrupt lines (switches, buttons); asynchronous to clk.
REQ-006 src_edge  input  N_SRC  per-source mode: 1 = rising-edge triggered, 0 = level triggered; quasi-static.
REQ-007 src_en  input  N_SRC  per-source enable mask.
REQ-008 irq_req  output  1  interrupt request to the core.
REQ-009 irq_id  output  clog2(N_SRC)  index of the requested source; valid while irq_req=1.
REQ-010 irq_ack  input  1  core accepts the request (one-cycle pulse).
REQ-011 irq_done  input  1  core finished the handler (one-cycle pulse, mret).
REQ-012 busy  output  1  handler in service.
REQ-013 pending  output  N_SRC  pending bits, for debug display.
REQ-014 ack_count  output  16  number of accepted interrupts; wraps modulo 2^16.

Function
REQ-015 Each src_irq bit passes through SYNC_STAGES flops, then a one-flop delayed copy for edge detection.
REQ-016 Edge mode: the pending bit is set on a synchronized 0->1 transition.
REQ-017 Edge mode: the pending bit is cleared on irq_ack of that source.
REQ-018 Edge mode: further edges while the bit is pending merge into the one pending bit, without counting.
REQ-019 Edge mode: a new edge in the same cycle as the clearing ack leaves the bit set (set wins).
REQ-020 Level mode: the pending bit equals the synchronized level and is not cleared by ack.
REQ-021 Latency: pending[i] rises SYNC_STAGES+1 clock edges after the first edge that samples src_irq[i] high.
REQ-022 Latency: irq_req rises one edge after pending[i] rises when the FSM is in IDLE.
REQ-023 FSM states: IDLE, REQ, SERVICE.
REQ-024 IDLE: if (pending & src_en) is nonzero, latch the lowest set index into irq_id and go to REQ (irq_req=1); otherwise stay.
REQ-025 REQ: irq_req and irq_id are held stable until irq_ack.
REQ-026 REQ: changes to src_en or pending do not withdraw or re-prioritise the request.
REQ-027 REQ: on irq_ack, go to SERVICE, drop irq_req on the same edge, and increment ack_count.
REQ-028 SERVICE: busy=1, no nesting; on irq_done go to IDLE.
REQ-029 After irq_done, a new request is allowed no earlier than the next edge, giving at least one cycle with irq_req=0.
REQ-030 irq_ack is ignored outside REQ; irq_done is ignored outside SERVICE.
REQ-031 irq_ack and irq_done asserted together in REQ: the ack is honoured and the done is ignored.
REQ-032 A level source deasserted during SERVICE is not re-requested; one still high after done is re-requested.
REQ-033 irq_id is held at its last value when irq_req=0.

Reset
REQ-034 While rst=1 the outputs are: irq_req=0, irq_id=0, busy=0, pending=0, ack_count=0.
REQ-035 While rst=1 the internal state is: FSM in IDLE, synchronizer and delay flops at 0.
REQ-036 Reset asserted mid-REQ or mid-SERVICE aborts the transaction immediately, with no ack counted.
REQ-037 After reset release, a source held high is seen as a rising edge once synchronized.

Structure
REQ-038 Shared package irq_pkg holds the FSM state encoding (2-bit: IDLE=0, REQ=1, SERVICE=2), the mode constants (EDGE=1, LEVEL=0), and the ID width function.
REQ-039 Sub-module irq_sync, instantiated once per source: synchronizer chain plus delay flop, with outputs level_s and rise_s.
REQ-040 Priority encoder, pending logic, FSM and counter are in irq_arbiter itself; no other sub-modules.

Verification
REQ-041 Edge source 2, SYNC_STAGES=2, src_irq[2] rises before edge 0 -> pending[2]=1 after edge 3, irq_req=1 and irq_id=2 after edge 4; ack -> pending[2]=0, busy=1, ack_count=1.
REQ-042 Edge sources 1 and 3 pending together -> irq_id=1 first; after ack, done, and one idle cycle -> irq_id=3; ack_count=2.
REQ-043 Level source 0 held high through done -> request again with irq_id=0; source 0 dropped during SERVICE -> no new request after done.
REQ-044 Edge on source 2 in the same cycle as ack of source 2 -> pending[2] stays 1 and is re-requested after done.
REQ-045 src_en[1] cleared while in REQ for source 1 -> request held until ack; ack outside REQ and done outside SERVICE -> no state change.
REQ-046 rst pulsed during SERVICE with ack_count=5 -> all outputs 0 asynchronously and FSM in IDLE.
